ccd_pixel_capture: RTL

//  Downstream of the CCD readout sequencer. Watches the ADC byte clock/output-enable lines it drives,

---
 rtl/ccd_pixel_capture_pkg.sv | 23 ++
 rtl/ccd_pixel_capture_if.sv | 11 +
 rtl/ccd_pixel_capture_pixel_fifo.sv | 73 +++++++
 rtl/ccd_pixel_capture.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ccd_pixel_capture_pkg.sv
// ccd_pixel_capture_pkg: capture FSM state encoding and pixel FIFO word layout
// {sof, sol, data[15:0]} shared by the capture block and its FIFO.
package ccd_pixel_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_MSB       = 2'd2,
    ST_LSB       = 2'd3
  } cap_state_e;

  localparam int FIFO_W      = 18;
  localparam int FW_SOF      = 17;
  localparam int FW_SOL      = 16;
  localparam int FW_DATA_MSB = 15;

  function automatic logic [FIFO_W-1:0] pack_word(input logic [15:0] data,
                                                  input logic        sof,
                                                  input logic        sol);
    return {sof, sol, data};
  endfunction

endpackage

// File: rtl/ccd_pixel_capture_if.sv
// ccd_pixel_capture_if: valid/ready pixel stream toward the host-transfer stage.
interface ccd_pixel_capture_if;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic        pix_sol;
  logic        pix_valid;
  logic        pix_ready;

  modport master (output pix_data, pix_sof, pix_sol, pix_valid, input pix_ready);
  modport slave  (input pix_data, pix_sof, pix_sol, pix_valid, output pix_ready);
endinterface

// File: rtl/ccd_pixel_capture_pixel_fifo.sv
// ccd_pixel_capture_pixel_fifo: synchronous pixel FIFO. A write against a full
// FIFO is accepted only if the head is read in the same cycle; otherwise it is
// dropped and flagged on wr_drop.
module ccd_pixel_capture_pixel_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             wr_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             rd_fire;
  logic             wr_fire;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign rd_fire = rd_en && !empty;
  assign wr_fire = wr_en && (!full || rd_fire);
  assign wr_drop = wr_en && !wr_fire;
  assign rd_data = mem_q[rd_ptr_q];

  // next storage contents, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage array; unreset because the head is only presented while non-empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ccd_pixel_capture.sv
// ccd_pixel_capture: samples the ADC byte bus on every ad_adclk edge, pairs
// MSB/LSB bytes into pixels, drops the ADC pipeline-latency pixels at each line
// start, tags start-of-frame/line and queues pixels for the host stage.
// Build macro CCD_CAPTURE_TEST_PATTERN_EN replaces ADC data with a pixel counter.
//
// state      | meaning
// IDLE       | out of reset, ignoring the ADC until armed
// WAIT_LINE  | armed, waiting for ad_oeb_n to fall (line start)
// MSB        | in line, next byte strobe is the pixel high byte
// LSB        | in line, next byte strobe is the low byte and completes a pixel
module ccd_pixel_capture
  import ccd_pixel_capture_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SAMPLE_DLY  = 2,
  parameter int DISCARD_PIX = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic [7:0]                 ad_data,
  input  logic                       ad_adclk,
  input  logic                       ad_oeb_n,
  ccd_pixel_capture_if.master        pix,
  output logic                       overflow,
  output logic                       sync_err,
  output logic [11:0]                line_count
);

  cap_state_e        state_q, state_d;
  logic              adclk_q, oeb_q;
  logic [3:0]        dly_cnt_q, dly_cnt_d;
  logic [7:0]        msb_q, msb_d;
  logic [2:0]        discard_q, discard_d;
  logic              sof_pend_q, sof_pend_d;
  logic              sol_pend_q, sol_pend_d;
  logic [11:0]       line_cnt_q, line_cnt_d;
  logic              ovf_q, ovf_d;
  logic              sync_err_q, sync_err_d;
  logic              wr_en_q, wr_en_d;
  logic [FIFO_W-1:0] wr_word_q, wr_word_d;

  logic              adclk_edge, byte_stb, sync_hit;
  logic              oeb_fall, oeb_rise;
  logic [15:0]       pix_val;
  logic [FIFO_W-1:0] head_word;
  logic              fifo_full, fifo_empty, fifo_drop;

  assign adclk_edge = adclk_q ^ ad_adclk;
  assign sync_hit   = adclk_edge && (dly_cnt_q != 4'd0);
  // a new edge on the terminal cycle kills the pending sample
  assign byte_stb   = (dly_cnt_q == 4'd1) && !adclk_edge;
  assign oeb_fall   = oeb_q && !ad_oeb_n;
  assign oeb_rise   = !oeb_q && ad_oeb_n;

`ifdef CCD_CAPTURE_TEST_PATTERN_EN
  logic [15:0] pat_cnt_q, pat_cnt_d;
  assign pix_val = pat_cnt_q;
`else
  assign pix_val = {msb_q, ad_data};
`endif

  // sample delay down-counter, reloaded on every adclk edge
  always_comb begin
    dly_cnt_d = dly_cnt_q;
    if (adclk_edge) begin
      dly_cnt_d = 4'(SAMPLE_DLY);
    end else if (dly_cnt_q != 4'd0) begin
      dly_cnt_d = dly_cnt_q - 4'd1;
    end
  end

  // capture FSM: line framing, byte pairing, discard and write request
  always_comb begin
    state_d    = state_q;
    msb_d      = msb_q;
    discard_d  = discard_q;
    sof_pend_d = sof_pend_q;
    sol_pend_d = sol_pend_q;
    line_cnt_d = line_cnt_q;
    ovf_d      = ovf_q | fifo_drop;
    sync_err_d = sync_err_q | sync_hit;
    wr_en_d    = 1'b0;
    wr_word_d  = wr_word_q;
`ifdef CCD_CAPTURE_TEST_PATTERN_EN
    pat_cnt_d  = pat_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_WAIT_LINE: begin
        if (oeb_fall) begin
          state_d    = ST_MSB;
          discard_d  = 3'(DISCARD_PIX);
          sol_pend_d = 1'b1;
          if (line_cnt_q != 12'hFFF) begin
            line_cnt_d = line_cnt_q + 12'd1;
          end
        end
      end
      ST_MSB: begin
        if (oeb_rise) begin
          state_d = ST_WAIT_LINE;
        end else if (byte_stb) begin
          msb_d   = ad_data;
          state_d = ST_LSB;
        end
      end
      ST_LSB: begin
        if (oeb_rise) begin
          state_d = ST_WAIT_LINE;
        end else if (byte_stb) begin
          state_d = ST_MSB;
          if (discard_q != 3'd0) begin
            discard_d = discard_q - 3'd1;
          end else begin
            wr_en_d    = 1'b1;
            wr_word_d  = pack_word(pix_val, sof_pend_q, sol_pend_q);
            sof_pend_d = 1'b0;
            sol_pend_d = 1'b0;
`ifdef CCD_CAPTURE_TEST_PATTERN_EN
            pat_cnt_d  = pat_cnt_q + 16'd1;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (arm) begin
      state_d    = ST_WAIT_LINE;
      sof_pend_d = 1'b1;
      line_cnt_d = 12'd0;
      ovf_d      = 1'b0;
      sync_err_d = 1'b0;
`ifdef CCD_CAPTURE_TEST_PATTERN_EN
      pat_cnt_d  = 16'd0;
`endif
    end
  end

  // input history for edge detection; unreset so it simply tracks the pins
  always_ff @(posedge clk) begin
    adclk_q <= ad_adclk;
    oeb_q   <= ad_oeb_n;
  end

  // capture state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dly_cnt_q  <= 4'd0;
      msb_q      <= 8'd0;
      discard_q  <= 3'd0;
      sof_pend_q <= 1'b0;
      sol_pend_q <= 1'b0;
      line_cnt_q <= 12'd0;
      ovf_q      <= 1'b0;
      sync_err_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_word_q  <= '0;
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      msb_q      <= msb_d;
      discard_q  <= discard_d;
      sof_pend_q <= sof_pend_d;
      sol_pend_q <= sol_pend_d;
      line_cnt_q <= line_cnt_d;
      ovf_q      <= ovf_d;
      sync_err_q <= sync_err_d;
      wr_en_q    <= wr_en_d;
      wr_word_q  <= wr_word_d;
    end
  end

`ifdef CCD_CAPTURE_TEST_PATTERN_EN
  // test pattern pixel counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_cnt_q <= 16'd0;
    end else begin
      pat_cnt_q <= pat_cnt_d;
    end
  end
`endif

  ccd_pixel_capture_pixel_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_q),
    .wr_data (wr_word_q),
    .rd_en   (pix.pix_ready),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .wr_drop (fifo_drop)
  );

  // head is masked while empty so stale entries never reach the bus
  assign pix.pix_valid = !fifo_empty;
  assign pix.pix_data  = fifo_empty ? 16'd0 : head_word[FW_DATA_MSB:0];
  assign pix.pix_sof   = !fifo_empty && head_word[FW_SOF];
  assign pix.pix_sol   = !fifo_empty && head_word[FW_SOL];

  assign overflow   = ovf_q;
  assign sync_err   = sync_err_q;
  assign line_count = line_cnt_q;

endmodule
